// File: rtl/seg7_count_display.sv
// Scans a 4-digit common-anode seven-segment display from a per-frame snapshot of an 8-bit count.
// Hex mode by default; define BCD_DISPLAY_EN for decimal display via a shift-add-3 converter.
module seg7_count_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef BCD_DISPLAY_EN
  localparam logic BLANK1_RST = 1'b1;
`else
  localparam logic BLANK1_RST = 1'b0;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          started_q;
  logic          frame_start;
  logic [3:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic          blank1_q, blank1_d, blank2_q, blank2_d;
  logic          busy_q, busy_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  // The first edge after reset release behaves like a 3->0 wrap so a frame starts at once.
  assign frame_start = !started_q || (cnt_q == LAST && idx_q == 2'd3);

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!started_q) begin
      cnt_d = '0;
      idx_d = 2'd0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef BCD_DISPLAY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  state_e      state_q, state_d;
  logic [19:0] sh_q, sh_d;
  logic [2:0]  bit_q, bit_d;

  function automatic logic [3:0] adj3(input logic [3:0] n);
    adj3 = (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    d0_d     = d0_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    blank1_d = blank1_q;
    blank2_d = blank2_q;
    case (state_q)
      IDLE: if (frame_start) begin
        sh_d    = {12'd0, value};
        bit_d   = 3'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sh_d  = {adj3(sh_q[19:16]), adj3(sh_q[15:12]), adj3(sh_q[11:8]), sh_q[7:0]} << 1;
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        d0_d     = sh_q[11:8];
        d1_d     = sh_q[15:12];
        d2_d     = sh_q[19:16];
        blank2_d = (sh_q[19:16] == 4'd0);
        blank1_d = (sh_q[19:16] == 4'd0) && (sh_q[15:12] == 4'd0);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
    end
  end
`else
  logic [7:0] snap_q;
  logic       load_q;

  always_comb begin
    d0_d     = d0_q;
    d1_d     = d1_q;
    d2_d     = 4'd0;
    blank1_d = 1'b0;
    blank2_d = 1'b1;
    busy_d   = 1'b0;
    if (load_q) begin
      d0_d = snap_q[3:0];
      d1_d = snap_q[7:4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q <= '0;
      load_q <= 1'b0;
    end else begin
      load_q <= frame_start;
      if (frame_start) snap_q <= value;
    end
  end
`endif

  always_comb begin
    an_d = ~(4'b0001 << idx_d);
    case (idx_d)
      2'd0:    seg_d = hex7(d0_q);
      2'd1:    seg_d = blank1_q ? BLANK : hex7(d1_q);
      2'd2:    seg_d = blank2_q ? BLANK : hex7(d2_q);
      default: seg_d = BLANK;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      started_q <= 1'b0;
      d0_q      <= 4'd0;
      d1_q      <= 4'd0;
      d2_q      <= 4'd0;
      blank1_q  <= BLANK1_RST;
      blank2_q  <= 1'b1;
      busy_q    <= 1'b0;
      seg_q     <= BLANK;
      an_q      <= 4'b1111;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      started_q <= 1'b1;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      blank1_q  <= blank1_d;
      blank2_q  <= blank2_d;
      busy_q    <= busy_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_seg7_count_display.sv
// Randomised bench for seg7_count_display; the reference model works from cycle numbers
// since reset release and plain decimal/hex arithmetic.
module tb_seg7_count_display;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;
`ifdef BCD_DISPLAY_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif
  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'h00;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  always #5 clk = ~clk;

  seg7_count_display #(.REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .value(value),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: digits are ints, -1 meaning blank.
  int         n;
  int         last_fs;
  int         load_at;
  int         disp [3];
  int         next_disp [3];
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_busy;

  function automatic logic [6:0] glyph(input int d);
    return (d < 0) ? 7'b1111111 : GLYPH[d];
  endfunction

  task automatic model_reset();
    n       = -1;
    last_fs = -1000;
    load_at = -1;
    disp    = '{0, (BCD ? -1 : 0), -1};
    m_an    = 4'b1111;
    m_seg   = 7'b1111111;
    m_busy  = 1'b0;
  endtask

  task automatic model_edge();
    int idx;
    int snap, h, t;
    n++;
    idx   = (n / RD) % 4;
    m_an  = ~(4'b0001 << idx);
    m_seg = (idx == 3) ? 7'b1111111 : glyph(disp[idx]);
    if (n == load_at) disp = next_disp;
    if (n % FRAME == 0) begin
      snap    = int'(value);
      last_fs = n;
      load_at = n + (BCD ? 9 : 1);
      if (BCD) begin
        h = snap / 100;
        t = (snap / 10) % 10;
        next_disp[0] = snap % 10;
        next_disp[1] = (h == 0 && t == 0) ? -1 : t;
        next_disp[2] = (h == 0) ? -1 : h;
      end else begin
        next_disp = '{snap % 16, snap / 16, -1};
      end
    end
    m_busy = BCD && (n - last_fs >= 0) && (n - last_fs <= 7);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check("an", 32'(an), 32'(m_an));
    check("seg", 32'(seg), 32'(m_seg));
    check("dp", 32'(dp), 32'd1);
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic wait_phase(input int ph);
    for (int k = 0; k < FRAME; k++) begin
      if (n % FRAME == ph) return;
      step();
    end
  endtask

  logic [7:0] fixed_vals [6] = '{8'h00, 8'hFF, 8'h07, 8'd105, 8'h3C, 8'h99};

  initial begin
    model_reset();
    value = 8'h3C;
    repeat (3) step();
    rst = 1'b0;
    repeat (3 * FRAME) step();

    wait_phase(6);
    value = 8'hA5;
    repeat (2 * FRAME) step();

    foreach (fixed_vals[i]) begin
      value = fixed_vals[i];
      repeat (2 * FRAME) step();
    end

    // Asynchronous reset a few cycles into a frame, i.e. mid-conversion in decimal mode.
    value = 8'd200;
    wait_phase(3);
    #2 rst = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_an", 32'(an), 32'hF);
    check("async_seg", 32'(seg), 32'h7F);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    value = 8'd254;
    repeat (2 * FRAME) step();

    repeat (40) begin
      value = 8'($urandom);
      repeat ($urandom_range(1, 20)) step();
    end
    repeat (2 * FRAME) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
